// File: rtl/elliptic_curve_structs.sv
// Shared curve constants and types for the ECDSA sign/verify datapaths.
// CURVE_N is the secp256k1 group order; the structs are 256-bit (r,s)
// signatures and affine (x,y) points.
package elliptic_curve_structs;
  localparam int CURVE_W = 256;
  localparam logic [CURVE_W-1:0] CURVE_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef struct packed {
    logic [CURVE_W-1:0] r;
    logic [CURVE_W-1:0] s;
  } signature_t;

  typedef struct packed {
    logic [CURVE_W-1:0] x;
    logic [CURVE_W-1:0] y;
  } curve_point_t;
endpackage

// File: rtl/ecdsa_sign_sequencer.sv
// ECDSA signing sequencer. Drives external hash, nonce, k*G, mod-n inverse
// and mod-n multiply units via start/done handshakes and computes
//   r = x(kG) mod n,  s = k^-1 * (e + r*d) mod n
// with range checks on d, k, r, s and bounded nonce retry.
// Ports:
//   clk, reset (sync, active-high)
//   init_sign/message/priv_key      : request, sampled when accepted in IDLE
//   done_sign/invalid_error/signature: one-cycle done, error level, result
//   start_hash/done_hash/hash_msg/hash_out       : hash unit
//   nonce_req/nonce_valid/nonce                  : nonce source
//   pm_start/pm_done/pm_scalar/pm_result         : k*G unit
//   inv_start/inv_done/inv_operand/inv_result    : mod-n inverse
//   mm_start/mm_done/mm_a/mm_b/mm_result         : mod-n multiply
module ecdsa_sign_sequencer #(
  parameter int             N_W       = 256,
  parameter logic [N_W-1:0] ORDER_N   = N_W'(elliptic_curve_structs::CURVE_N),
  parameter int             MAX_RETRY = 4,
  parameter type signature_t   = elliptic_curve_structs::signature_t,
  parameter type curve_point_t = elliptic_curve_structs::curve_point_t
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_sign,
  input  logic [95:0]      message,
  input  logic [N_W-1:0]   priv_key,
  output logic             done_sign,
  output logic             invalid_error,
  output signature_t       signature,
  output logic             start_hash,
  input  logic             done_hash,
  output logic [95:0]      hash_msg,
  input  logic [N_W-1:0]   hash_out,
  output logic             nonce_req,
  input  logic             nonce_valid,
  input  logic [N_W-1:0]   nonce,
  output logic             pm_start,
  input  logic             pm_done,
  output logic [N_W-1:0]   pm_scalar,
  input  curve_point_t     pm_result,
  output logic             inv_start,
  input  logic             inv_done,
  output logic [N_W-1:0]   inv_operand,
  input  logic [N_W-1:0]   inv_result,
  output logic             mm_start,
  input  logic             mm_done,
  output logic [N_W-1:0]   mm_a,
  output logic [N_W-1:0]   mm_b,
  input  logic [N_W-1:0]   mm_result
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [4:0] {
    IDLE, HASH_START, HASH_WAIT, NONCE_REQ, NONCE_WAIT, PM_START, PM_WAIT,
    R_CALC, INV_START, INV_WAIT, MRD_START, MRD_WAIT, ADD_E, MS_START,
    MS_WAIT, S_CHECK, DONE, ERROR
  } state_t;

  state_t state_q, state_d;
  logic [95:0]    msg_q;
  logic [N_W-1:0] d_q, e_q, k_q, x_q, r_q, kinv_q, t_q, u_q, s_q;
  logic [RW-1:0]  retry_q;
  logic           reject, retry_hit, d_bad, k_bad;
  logic [N_W-1:0] e_red, r_calc;
  logic [N_W:0]   u_wide, u_red;

  // Only x(kG) feeds r; y is carried by the point type but not needed.
  logic unused_pm_y;
  assign unused_pm_y = ^pm_result.y;

  assign d_bad     = (d_q == '0) || (d_q >= ORDER_N);
  assign k_bad     = (nonce == '0) || (nonce >= ORDER_N);
  assign retry_hit = (int'(retry_q) + 1) == MAX_RETRY;
  // Single conditional subtracts: e and x are below 2n for real curves.
  assign e_red  = (hash_out >= ORDER_N) ? hash_out - ORDER_N : hash_out;
  assign r_calc = (x_q >= ORDER_N) ? x_q - ORDER_N : x_q;
  // e, t < n so e + t < 2n; one extra bit keeps the carry.
  assign u_wide = {1'b0, e_q} + {1'b0, t_q};
  assign u_red  = (u_wide >= {1'b0, ORDER_N}) ? u_wide - {1'b0, ORDER_N} : u_wide;

  always_comb begin
    state_d     = state_q;
    reject      = 1'b0;
    start_hash  = 1'b0;
    nonce_req   = 1'b0;
    pm_start    = 1'b0;
    inv_start   = 1'b0;
    mm_start    = 1'b0;
    hash_msg    = '0;
    pm_scalar   = '0;
    inv_operand = '0;
    mm_a        = '0;
    mm_b        = '0;
    case (state_q)
      IDLE:       if (init_sign) state_d = HASH_START;
      HASH_START: if (d_bad) state_d = ERROR;
                  else begin
                    start_hash = 1'b1;
                    hash_msg   = msg_q;
                    state_d    = HASH_WAIT;
                  end
      HASH_WAIT: begin
        hash_msg = msg_q;
        if (done_hash) state_d = NONCE_REQ;
      end
      NONCE_REQ: begin
        nonce_req = 1'b1;
        state_d   = NONCE_WAIT;
      end
      NONCE_WAIT: if (nonce_valid) begin
        if (k_bad) reject = 1'b1;
        else       state_d = PM_START;
      end
      PM_START: begin
        pm_start  = 1'b1;
        pm_scalar = k_q;
        state_d   = PM_WAIT;
      end
      PM_WAIT: begin
        pm_scalar = k_q;
        if (pm_done) state_d = R_CALC;
      end
      R_CALC: if (r_calc == '0) reject = 1'b1;
              else state_d = INV_START;
      INV_START: begin
        inv_start   = 1'b1;
        inv_operand = k_q;
        state_d     = INV_WAIT;
      end
      INV_WAIT: begin
        inv_operand = k_q;
        if (inv_done) state_d = MRD_START;
      end
      MRD_START: begin
        mm_start = 1'b1;
        mm_a     = r_q;
        mm_b     = d_q;
        state_d  = MRD_WAIT;
      end
      MRD_WAIT: begin
        mm_a = r_q;
        mm_b = d_q;
        if (mm_done) state_d = ADD_E;
      end
      ADD_E: state_d = MS_START;
      MS_START: begin
        mm_start = 1'b1;
        mm_a     = kinv_q;
        mm_b     = u_q;
        state_d  = MS_WAIT;
      end
      MS_WAIT: begin
        mm_a = kinv_q;
        mm_b = u_q;
        if (mm_done) state_d = S_CHECK;
      end
      S_CHECK: if (s_q == '0) reject = 1'b1;
               else state_d = DONE;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Retries restart at the nonce; e stays valid so the hash is not rerun.
    if (reject) state_d = retry_hit ? ERROR : NONCE_REQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      done_sign     <= 1'b0;
      invalid_error <= 1'b0;
      signature     <= '0;
      msg_q         <= '0;
      d_q           <= '0;
      e_q           <= '0;
      k_q           <= '0;
      x_q           <= '0;
      r_q           <= '0;
      kinv_q        <= '0;
      t_q           <= '0;
      u_q           <= '0;
      s_q           <= '0;
      retry_q       <= '0;
    end else begin
      state_q <= state_d;
      // A good signature is known in S_CHECK and lands as DONE is entered;
      // ERROR is a clean-up cycle whose results land with the pulse after it.
      done_sign <= (state_d == DONE) || (state_q == ERROR);
      if (reject) retry_q <= retry_q + RW'(1);
      case (state_q)
        IDLE: if (init_sign) begin
          msg_q         <= message;
          d_q           <= priv_key;
          retry_q       <= '0;
          invalid_error <= 1'b0;
        end
        HASH_WAIT:  if (done_hash)   e_q    <= e_red;
        NONCE_WAIT: if (nonce_valid) k_q    <= nonce;
        PM_WAIT:    if (pm_done)     x_q    <= pm_result.x;
        R_CALC:                      r_q    <= r_calc;
        INV_WAIT:   if (inv_done)    kinv_q <= inv_result;
        MRD_WAIT:   if (mm_done)     t_q    <= mm_result;
        ADD_E:                       u_q    <= u_red[N_W-1:0];
        MS_WAIT:    if (mm_done)     s_q    <= mm_result;
        S_CHECK: if (state_d == DONE) begin
          signature.r <= r_q;
          signature.s <= s_q;
        end
        ERROR: begin
          signature     <= '0;
          invalid_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ecdsa_sign_sequencer.md
# ecdsa_sign_sequencer

Signing-side counterpart to the ECDSA verify path: it takes a message and a private key and produces a signature (r, s) for the verifier to consume. It sequences external hash, nonce-source, point-multiply, mod-n inverse and mod-n multiply units through start/done handshakes. It performs the reductions, mod-n addition, range checks and nonce-retry logic internally. Signature and point types come from elliptic_curve_structs.

## Interface
- N_W, 256, scalar width; equals width of signature_t.r/.s and curve_point_t.x
- ORDER_N, curve order n from elliptic_curve_structs, group order used for all mod-n checks/reductions
- MAX_RETRY, 4, rejected nonces tolerated before error (≥1)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- init_sign  in  1  start request; honoured only in IDLE
- message  in  96  message, sampled on accepted init_sign
- priv_key  in  N_W  d, sampled on accepted init_sign
- done_sign  out  1  one-cycle completion pulse (success or error)
- invalid_error  out  1  level; set on entering ERROR, cleared on next accepted init_sign
- signature  out  signature_t  (r, s); held stable until next accepted init_sign
- start_hash / done_hash / hash_msg / hash_out  out 1 / in 1 / out 96 / in N_W  hash unit; hash_out is truncated e
- nonce_req / nonce_valid / nonce  out 1 / in 1 / in N_W  nonce source
- pm_start / pm_done / pm_scalar / pm_result  out 1 / in 1 / out N_W / in curve_point_t  k·G unit
- inv_start / inv_done / inv_operand / inv_result  out 1 / in 1 / out N_W / in N_W  mod-n inverse
- mm_start / mm_done / mm_a / mm_b / mm_result  out 1 / in 1 / out N_W / out N_W / in N_W  mod-n multiply

## Operation
- States: IDLE, HASH_START, HASH_WAIT, NONCE_REQ, NONCE_WAIT, PM_START, PM_WAIT, R_CALC, INV_START, INV_WAIT, MRD_START, MRD_WAIT, ADD_E, MS_START, MS_WAIT, S_CHECK, DONE, ERROR.
- IDLE: on init_sign, latch message and d, clear retry count, clear invalid_error, go HASH_START.
- HASH_START: if d==0 or d≥n, go ERROR without pulsing start_hash. Otherwise pulse start_hash and go HASH_WAIT. Latch e on done_hash.
- NONCE_REQ: pulse nonce_req. NONCE_WAIT: on nonce_valid, latch k. If k==0 or k≥n, reject; otherwise go PM_START.
- PM_START: pm_scalar=k. On pm_done, latch x.
- R_CALC: r = x≥n ? x−n : x (single conditional subtract). If r==0, reject.
- INV_START: inv_operand=k. Latch kinv.
- MRD_START: mm_a=r, mm_b=d. Latch t.
- ADD_E: u = e+t computed N_W+1 bits wide. Subtract n if u≥n (e<2^N_W, t<n, so one subtract suffices only when e<n; e is first reduced: e≥n → e−n at latch).
- MS_START: mm_a=kinv, mm_b=u. Latch s. S_CHECK: if s==0, reject; otherwise DONE.
- Reject: retry count +1. If count==MAX_RETRY, go ERROR; else go NONCE_REQ (hash is not redone).
- DONE: signature←(r,s), pulse done_sign, go IDLE.
- ERROR: signature←0, invalid_error←1, pulse done_sign, go IDLE.
- Operand outputs stay stable from the start pulse through the matching done.

## Timing
- Reset: state IDLE, all outputs 0 (done_sign, invalid_error, signature, every *_start, nonce_req, operand buses). Reset mid-operation aborts immediately. Late done/valid pulses arriving in IDLE are ignored.
- All start/req outputs are one-cycle pulses. done/valid inputs are one-cycle pulses, and data is captured in the same cycle.
- init_sign outside IDLE is ignored. init_sign in the DONE/ERROR cycle is ignored.
- Lx = cycles from a start pulse to its done (≥1).
- Success with no retries: init accepted at cycle 0, done_sign at cycle 10+Lh+Ln+Lpm+Linv+2·Lmm.
- Each retry adds 1 cycle plus the units rerun from NONCE_REQ.
- Invalid d: done_sign at cycle 3.

## Test plan
- N_W=8, ORDER_N=19, d=7, e=5, k=3, pm x=22, bench mod-19 models -> r=3, kinv=13, s=15; signature (3,15), invalid_error 0, latency matches formula.
- Same, but first nonce 3 returns pm x=19 (r=0), second nonce 3 returns x=22 -> exactly two nonce_req pulses, signature (3,15).
- e=18 -> u wraps to 1 -> signature (3,13). e=17 -> s=0 -> reject, nonce re-requested.
- MAX_RETRY=2, nonces 0 then 19 -> ERROR: done_sign pulse, invalid_error=1, signature 0. Next init clears invalid_error.
- priv_key=0 -> no start_hash, done_sign at cycle 3, invalid_error=1. init_sign asserted during PM_WAIT -> ignored.
- reset asserted in PM_WAIT -> all outputs 0 next cycle. A following pm_done is ignored. A fresh init then completes normally.
